// File: rtl/input_csr.sv
// input_csr: CSR-mapped receive byte FIFO at address 0x0FE with async active-high reset.
// Define INPUT_CSR_OVF_EN to add the sticky overflow flag on read-data bit 1.
module input_csr #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [11:0] cadr_i,
    output logic        cvalid_o,
    output logic [63:0] cdat_o,
    input  logic [63:0] cdat_i,
    input  logic        coe_i,
    input  logic        cwe_i,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_stb_i,
    output logic        rx_ack_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, avail, push, pop, flush, ovf;
    logic [7:0]    head;

    assign cvalid_o = (cadr_i == 12'h0FE);
    assign full     = (count_q == FULL_COUNT);
    assign avail    = (count_q != '0);
    assign head     = avail ? mem_q[rptr_q] : 8'h00;
    // Ack is masked by reset itself so it drops the moment reset asserts, not at the next edge.
    assign rx_ack_o = rx_stb_i & ~full & ~reset_i;
    assign push     = rx_ack_o;
    assign pop      = cvalid_o & coe_i & avail;
    assign flush    = cvalid_o & cwe_i & cdat_i[0];
    assign cdat_o   = cvalid_o ? {52'd0, avail, head, 1'b1, ovf, 1'b0} : 64'd0;

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the byte array has no reset; count gates the head, so stale bytes are never visible.
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem_q[wptr_q] <= rx_dat_i;
    end

`ifdef INPUT_CSR_OVF_EN
    logic ovf_q, ovf_d;
    logic unused_cdat;

    // Set beats a same-cycle clear so a refused byte is never silently forgotten.
    always_comb begin
        ovf_d = ovf_q;
        if (cvalid_o & cwe_i & cdat_i[1]) ovf_d = 1'b0;
        if (rx_stb_i & full)              ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    assign ovf         = ovf_q;
    assign unused_cdat = ^cdat_i[63:2];
`else
    logic unused_cdat;

    assign ovf         = 1'b0;
    assign unused_cdat = ^cdat_i[63:1];
`endif
endmodule

// File: tb/tb_input_csr.sv
// Self-checking bench for input_csr: directed scenarios then random traffic against a queue model.
module tb_input_csr;
    localparam int DEPTH = 4;
`ifdef INPUT_CSR_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [11:0] cadr_i;
    logic        cvalid_o;
    logic [63:0] cdat_o;
    logic [63:0] cdat_i;
    logic        coe_i;
    logic        cwe_i;
    logic [7:0]  rx_dat_i;
    logic        rx_stb_i;
    logic        rx_ack_o;

    input_csr #(.DEPTH(DEPTH)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .cadr_i   (cadr_i),
        .cvalid_o (cvalid_o),
        .cdat_o   (cdat_o),
        .cdat_i   (cdat_i),
        .coe_i    (coe_i),
        .cwe_i    (cwe_i),
        .rx_dat_i (rx_dat_i),
        .rx_stb_i (rx_stb_i),
        .rx_ack_o (rx_ack_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] q[$];
    bit         m_ovf;
    int         n_pass;
    int         n_total;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [63:0] exp_cdat();
        logic [63:0] r;
        r = '0;
        if (cadr_i == 12'h0FE) begin
            r[2] = 1'b1;
            r[1] = m_ovf;
            if (q.size() != 0) begin
                r[11]   = 1'b1;
                r[10:3] = q[0];
            end
        end
        return r;
    endfunction

    function automatic logic exp_ack();
        return rx_stb_i && !reset_i && (q.size() < DEPTH);
    endfunction

    task automatic model_edge();
        bit sel, full, flush, pop, ack;
        sel   = (cadr_i == 12'h0FE);
        full  = (q.size() == DEPTH);
        ack   = rx_stb_i && !full;
        pop   = sel && coe_i && (q.size() != 0);
        flush = sel && cwe_i && cdat_i[0];
        if (OVF_EN) begin
            if (sel && cwe_i && cdat_i[1]) m_ovf = 1'b0;
            if (rx_stb_i && full)          m_ovf = 1'b1;
        end
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (ack) q.push_back(rx_dat_i);
        end
    endtask

    task automatic tick(input string tag);
        #2;
        if (reset_i) begin
            q.delete();
            m_ovf = 1'b0;
        end
        check({tag, ".cvalid"}, 64'(cvalid_o), 64'(cadr_i == 12'h0FE));
        check({tag, ".cdat"}, cdat_o, exp_cdat());
        check({tag, ".ack"}, 64'(rx_ack_o), 64'(exp_ack()));
        if (!reset_i) model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cadr_i   = 12'h000;
        cdat_i   = 64'd0;
        coe_i    = 1'b0;
        cwe_i    = 1'b0;
        rx_stb_i = 1'b0;
        rx_dat_i = 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        idle();
        rx_stb_i = 1'b1;
        rx_dat_i = b;
        tick("push");
    endtask

    task automatic rd(input string tag, input logic oe);
        idle();
        cadr_i = 12'h0FE;
        coe_i  = oe;
        tick(tag);
    endtask

    task automatic csr_write(input logic [63:0] d);
        idle();
        cadr_i = 12'h0FE;
        cwe_i  = 1'b1;
        cdat_i = d;
        tick("csr_write");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_ovf   = 1'b0;
        idle();
        reset_i  = 1'b1;
        cadr_i   = 12'h0FE;
        rx_stb_i = 1'b1;
        coe_i    = 1'b1;
        cwe_i    = 1'b1;
        cdat_i   = 64'h3;
        #2;
        check("rst_ack", 64'(rx_ack_o), 64'd0);
        check("rst_cdat", cdat_o, 64'h4);
        @(posedge clk_i);
        #1;
        tick("rst_hold");
        reset_i = 1'b0;
        idle();

        // Single byte: visible on the next cycle, gone after a read with coe_i.
        push(8'h41);
        idle();
        cadr_i = 12'h0FE;
        #1;
        check("r029_read", cdat_o, 64'hA0C);
        tick("r029_peek");
        rd("r029_pop", 1'b1);
        idle();
        cadr_i = 12'h0FE;
        #1;
        check("r029_empty", cdat_o, 64'h4);
        tick("r029_empty");

        // Fill to DEPTH, refused fifth byte, in-order drain.
        for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
        idle();
        rx_stb_i = 1'b1;
        rx_dat_i = 8'h35;
        #1;
        check("r030_full_ack", 64'(rx_ack_o), 64'd0);
        tick("r030_refuse");
        for (int i = 0; i < 4; i++) begin
            idle();
            cadr_i = 12'h0FE;
            coe_i  = 1'b1;
            #1;
            check("r030_pop", 64'(cdat_o[10:3]), 64'(8'h31 + 8'(i)));
            tick("r030_pop");
        end
        idle();
        cadr_i = 12'h0FE;
        #1;
        check("r030_ovf", 64'(cdat_o[1]), 64'(OVF_EN));
        tick("r030_ovf");
        csr_write(64'h2);

        // Read without coe_i leaves the head in place.
        push(8'h99);
        push(8'h9A);
        for (int i = 0; i < 3; i++) begin
            idle();
            cadr_i = 12'h0FE;
            #1;
            check("r031_hold", cdat_o, 64'h800 | (64'h99 << 3) | 64'h4);
            tick("r031_hold");
        end
        rd("r031_pop1", 1'b1);
        rd("r031_pop2", 1'b1);
        rd("r031_empty", 1'b0);

        // Flush plus OVF clear with a same-cycle accepted push.
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        push(8'h14);
        rd("r032_pop", 1'b1);
        rd("r032_pop", 1'b1);
        idle();
        cadr_i   = 12'h0FE;
        cwe_i    = 1'b1;
        cdat_i   = 64'h3;
        rx_stb_i = 1'b1;
        rx_dat_i = 8'h55;
        tick("r032_flush");
        idle();
        cadr_i = 12'h0FE;
        #1;
        check("r032_after", cdat_o, 64'h4);
        tick("r032_after");

        // Full with pop and push in the same cycle: push still refused.
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
        idle();
        cadr_i   = 12'h0FE;
        coe_i    = 1'b1;
        rx_stb_i = 1'b1;
        rx_dat_i = 8'h25;
        #1;
        check("r019_ack", 64'(rx_ack_o), 64'd0);
        tick("r019_pop_push");
        for (int i = 0; i < 3; i++) rd("r019_drain", 1'b1);
        idle();
        cadr_i = 12'h0FE;
        #1;
        check("r019_empty", 64'(cdat_o[11]), 64'd0);
        tick("r019_empty");
        csr_write(64'h2);

        // Empty with push and read together: AVAIL 0 now, byte next cycle.
        idle();
        cadr_i   = 12'h0FE;
        coe_i    = 1'b1;
        rx_stb_i = 1'b1;
        rx_dat_i = 8'h66;
        #1;
        check("r020_avail", 64'(cdat_o[11]), 64'd0);
        tick("r020_push_read");
        idle();
        cadr_i = 12'h0FE;
        #1;
        check("r020_byte", 64'(cdat_o[10:3]), 64'h66);
        tick("r020_byte");
        rd("r020_pop", 1'b1);

        // Asynchronous reset between edges with data queued.
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
        idle();
        cadr_i   = 12'h0FE;
        rx_stb_i = 1'b1;
        rx_dat_i = 8'h11;
        #1;
        check("r033_pre_ack", 64'(rx_ack_o), 64'd1);
        reset_i = 1'b1;
        #1;
        check("r033_ack", 64'(rx_ack_o), 64'd0);
        check("r033_avail", 64'(cdat_o[11]), 64'd0);
        q.delete();
        m_ovf = 1'b0;
        #1;
        reset_i = 1'b0;
        idle();
        push(8'h7A);
        idle();
        cadr_i = 12'h0FE;
        coe_i  = 1'b1;
        #1;
        check("r033_first", 64'(cdat_o[10:3]), 64'h7A);
        tick("r033_pop");
        rd("r033_empty", 1'b0);

        // Wrong address: no select, no pop, no flush.
        push(8'h42);
        idle();
        cadr_i = 12'h0FF;
        coe_i  = 1'b1;
        cwe_i  = 1'b1;
        cdat_i = 64'h3;
        #1;
        check("r034_cvalid", 64'(cvalid_o), 64'd0);
        check("r034_cdat", cdat_o, 64'd0);
        tick("r034_miss");
        idle();
        cadr_i = 12'h0FE;
        #1;
        check("r034_kept", 64'(cdat_o[10:3]), 64'h42);
        tick("r034_kept");
        rd("r034_pop", 1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            idle();
            reset_i  = ($urandom_range(0, 99) == 0);
            cadr_i   = ($urandom_range(0, 1) == 1) ? 12'h0FE : 12'($urandom);
            coe_i    = 1'($urandom);
            cwe_i    = ($urandom_range(0, 3) == 0);
            cdat_i   = {$urandom, $urandom};
            cdat_i[0] = ($urandom_range(0, 3) == 0);
            rx_stb_i = ($urandom_range(0, 9) < 6);
            rx_dat_i = 8'($urandom);
            tick("rand");
        end
        reset_i = 1'b0;
        idle();
        tick("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/input_csr.md
INPUT_CSR -- requirements
Module: input_csr

Interface
REQ-001 SHALL have parameter DEPTH, default 4, receive FIFO depth in bytes; legal values are powers of two, 2..16.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port cadr_i, input, 12, CSR address.
REQ-005 SHALL have port cvalid_o, output, 1, CSR selected.
REQ-006 SHALL have port cdat_o, output, 64, CSR read data.
REQ-007 SHALL have port cdat_i, input, 64, CSR write data.
REQ-008 SHALL have port coe_i, input, 1, enables read side-effects.
REQ-009 SHALL have port cwe_i, input, 1, enables write side-effects.
REQ-010 SHALL have port rx_dat_i, input, 8, byte from host/testbench character source.
REQ-011 SHALL have port rx_stb_i, input, 1, rx_dat_i valid this cycle.
REQ-012 SHALL have port rx_ack_o, output, 1, byte accepted this cycle.

Function
REQ-013 SHALL decode cvalid_o combinationally as (cadr_i == 12'h0FE), valid in the first cycle of any CSR instruction.
REQ-014 SHALL drive cdat_o combinationally, independent of coe_i: 0 when not selected; otherwise bit 11 = AVAIL (FIFO non-empty), bits 10:3 = head byte (0 when empty), bit 2 = 1, bit 1 = OVF, bit 0 = 0, bits 63:12 = 0.
REQ-015 SHALL assert rx_ack_o = rx_stb_i & ~full, where full is the registered count == DEPTH.
REQ-016 SHALL push rx_dat_i at the tail on the clock edge when rx_ack_o is 1.
REQ-017 SHALL pop the head on the clock edge when cvalid_o & coe_i & AVAIL; a read while empty has no effect.
REQ-018 SHALL keep count unchanged on simultaneous push and pop; the popped byte is the one shown on cdat_o in that cycle.
REQ-019 SHALL refuse a push when full, even if a pop occurs in the same cycle.
REQ-020 SHALL, when empty with push and read in the same cycle, return AVAIL=0 and store the pushed byte; the byte is visible the next cycle.
REQ-021 SHALL flush the FIFO (count = 0) on the edge when cvalid_o & cwe_i & cdat_i[0].
REQ-022 SHALL let flush win over a same-cycle pop and push; the pushed byte is discarded and does not set OVF.
REQ-023 SHALL wrap read and write pointers modulo DEPTH, using a log2(DEPTH)+1-bit count.
REQ-024 SHALL produce a byte order at pop identical to the accept order.

Reset
REQ-025 SHALL, while reset_i is asserted, immediately force count = 0, pointers = 0, OVF = 0, rx_ack_o = 0, AVAIL = 0, and head byte field = 0.
REQ-026 SHALL, on reset mid-operation, lose all FIFO contents; the first accepted byte after release is the first popped.

Configuration
REQ-027 SHALL, with INPUT_CSR_OVF_EN defined, set sticky OVF when rx_stb_i & full, and clear it on the edge when cvalid_o & cwe_i & cdat_i[1]; set takes priority over a same-cycle clear.
REQ-028 SHALL, without INPUT_CSR_OVF_EN, read OVF as 0, ignore cdat_i[1], and contain no OVF flop.

Verification
REQ-029 SHALL cover: reset, then push 0x41 -> next cycle cadr_i=0x0FE reads cdat_o=0x0000_0000_0000_0A0C; read with coe_i=1 -> next read 0x4.
REQ-030 SHALL cover: push 0x31..0x34 with DEPTH=4, then stb 0x35 -> rx_ack_o=0; pops return 0x31,0x32,0x33,0x34 in order; OVF=1 with macro, 0 without.
REQ-031 SHALL cover: read with coe_i=0 while non-empty -> AVAIL=1 and same byte on every cycle, count unchanged.
REQ-032 SHALL cover: 2 bytes queued, then write cdat_i=0x3 with same-cycle stb 0x55 -> cdat_o=0x4 afterwards, OVF cleared, 0x55 not stored.
REQ-033 SHALL cover: 3 bytes queued, reset_i pulsed between clock edges -> rx_ack_o and cdat_o[11] drop at once; push 0x7A -> pop yields 0x7A.
REQ-034 SHALL cover: cadr_i=0x0FF with coe_i=1 and cwe_i=1 -> cvalid_o=0, cdat_o=0, no pop or flush.
